// File: rtl/spi_fsm_controller_if.sv
// spi_fsm_controller_if: conditioned SPI inputs and datapath strobes of the transaction sequencer
interface spi_fsm_controller_if;
  logic sclkPosEdge;
  logic csConditioned;
  logic rwBit;
  logic srParallelLoad;
  logic addrLatchEnable;
  logic dmWriteEnable;
  logic misoBufferEnable;
  modport master (
    output sclkPosEdge, csConditioned, rwBit,
    input  srParallelLoad, addrLatchEnable, dmWriteEnable, misoBufferEnable
  );
  modport slave (
    input  sclkPosEdge, csConditioned, rwBit,
    output srParallelLoad, addrLatchEnable, dmWriteEnable, misoBufferEnable
  );
endinterface

// File: rtl/spi_fsm_controller.sv
// spi_fsm_controller: counts SCLK edges under CS, decodes R/W and sequences the
// shift-register load, address latch, memory write and MISO enable strobes.
module spi_fsm_controller #(
  parameter int addrBits = 7,
  parameter int dataBits = 8
) (
  input logic clk,
  input logic reset_n,
  spi_fsm_controller_if.slave bus
);
  localparam int HB = addrBits + 1;
  localparam int CW = $clog2((HB > dataBits ? HB : dataBits) + 1);
  typedef enum logic [3:0] {
    IDLE, ADDR_SHIFT, ADDR_LATCH, READ_WAIT, READ_LOAD,
    READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE
  } state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic hdr_last, dat_last;
  assign cnt_inc  = cnt + CW'(bus.sclkPosEdge);
  assign hdr_last = bus.sclkPosEdge && cnt == CW'(addrBits);
  assign dat_last = bus.sclkPosEdge && cnt == CW'(dataBits - 1);
  // CS high dominates every state, so an abort always wins over a coincident edge
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    if (bus.csConditioned) begin
      nxt = IDLE;
      cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt = ADDR_SHIFT;
          cnt_nxt = '0;
        end
        ADDR_SHIFT: begin
          nxt = hdr_last ? ADDR_LATCH : ADDR_SHIFT;
          cnt_nxt = hdr_last ? '0 : cnt_inc;
        end
        ADDR_LATCH: nxt = bus.rwBit ? READ_WAIT : WRITE_SHIFT;
        READ_WAIT:  nxt = READ_LOAD;
        READ_LOAD:  nxt = READ_SHIFT;
        READ_SHIFT: begin
          nxt = dat_last ? DONE : READ_SHIFT;
          cnt_nxt = dat_last ? '0 : cnt_inc;
        end
        WRITE_SHIFT: begin
          nxt = dat_last ? WRITE_MEM : WRITE_SHIFT;
          cnt_nxt = dat_last ? '0 : cnt_inc;
        end
        WRITE_MEM: nxt = DONE;
        default:   nxt = state;
      endcase
    end
  end
  // Strobes are registered from the next state so they track the state register exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.addrLatchEnable <= 1'b0;
      bus.srParallelLoad <= 1'b0;
      bus.dmWriteEnable <= 1'b0;
      bus.misoBufferEnable <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      bus.addrLatchEnable <= nxt == ADDR_LATCH;
      bus.srParallelLoad <= nxt == READ_LOAD;
      bus.dmWriteEnable <= nxt == WRITE_MEM;
      bus.misoBufferEnable <= nxt == READ_SHIFT;
    end
  end
endmodule

// File: tb/tb_spi_fsm_controller.sv
// tb_spi_fsm_controller: directed transactions; expected strobe vectors are queued
// as each cycle is driven and compared one clock later.
module tb_spi_fsm_controller;
  localparam logic [3:0] ALE = 4'b1000, SRL = 4'b0100, DME = 4'b0010, MISO = 4'b0001, NONE = 4'b0000;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rb = 1'b0;
  logic [3:0] sb[$];
  int checks = 0;
  int passed = 0;
  spi_fsm_controller_if bus();
  spi_fsm_controller #(.addrBits(7), .dataBits(8)) dut (
    .clk(clk),
    .reset_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag);
    logic [3:0] o, e;
    o = {bus.addrLatchEnable, bus.srParallelLoad, bus.dmWriteEnable, bus.misoBufferEnable};
    e = sb.pop_front();
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s: strobes {ale,srl,dme,miso} got %b expected %b at %0t", tag, o, e, $time);
  endtask
  task automatic cyc(input string tag, input logic s, input logic c, input logic [3:0] e);
    bus.sclkPosEdge = s;
    bus.csConditioned = c;
    bus.rwBit = rb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag);
    bus.sclkPosEdge = 1'b0;
  endtask
  // rwBit follows the last bit shifted in, so after the header it holds the R/W bit
  task automatic header(input logic [7:0] h, input logic fall_sclk);
    cyc("cs_fall", fall_sclk, 1'b0, NONE);
    for (int i = 7; i >= 0; i--) begin
      cyc("hdr_edge", 1'b1, 1'b0, i == 0 ? ALE : NONE);
      rb = h[i];
      if (i > 0) repeat (3) cyc("hdr_gap", 1'b0, 1'b0, NONE);
    end
    cyc("rw_sample", 1'b0, 1'b0, NONE);
    cyc("rd_load", 1'b0, 1'b0, h[0] ? SRL : NONE);
    cyc("rd_shift_start", 1'b0, 1'b0, h[0] ? MISO : NONE);
  endtask
  task automatic data(input int n, input logic rd);
    for (int k = 1; k <= n; k++) begin
      cyc("data_edge", 1'b1, 1'b0, k == 8 ? (rd ? NONE : DME) : (rd ? MISO : NONE));
      if (k < 8) repeat (3) cyc("data_gap", 1'b0, 1'b0, rd ? MISO : NONE);
      else if (!rd) cyc("wr_done", 1'b0, 1'b0, NONE);
    end
  endtask
  task automatic end_txn();
    cyc("done_hold", 1'b1, 1'b0, NONE);
    cyc("done_hold", 1'b0, 1'b0, NONE);
    cyc("cs_rise", 1'b0, 1'b1, NONE);
    cyc("idle", 1'b0, 1'b1, NONE);
  endtask
  initial begin
    bus.sclkPosEdge = 1'b0;
    bus.csConditioned = 1'b1;
    bus.rwBit = 1'b0;
    #2 rst_n = 1'b0;
    sb.push_back(NONE);
    #1 chk("reset_state");
    cyc("in_reset", 1'b1, 1'b0, NONE);
    cyc("in_reset", 1'b0, 1'b1, NONE);
    #4 rst_n = 1'b1;
    cyc("idle", 1'b1, 1'b1, NONE);
    // write 0x2A <- 0xC3
    header({7'h2A, 1'b0}, 1'b0);
    data(8, 1'b0);
    end_txn();
    // read 0x15
    header({7'h15, 1'b1}, 1'b0);
    data(8, 1'b1);
    end_txn();
    // abort a write after 5 data edges, then a clean write
    header({7'h2A, 1'b0}, 1'b0);
    data(5, 1'b0);
    cyc("abort_data", 1'b0, 1'b1, NONE);
    cyc("abort_idle", 1'b0, 1'b1, NONE);
    header({7'h2A, 1'b0}, 1'b0);
    data(8, 1'b0);
    end_txn();
    // abort with coincident edge mid-header, then an edge on the CS-fall cycle
    cyc("cs_fall", 1'b0, 1'b0, NONE);
    repeat (3) begin
      cyc("hdr_edge", 1'b1, 1'b0, NONE);
      repeat (3) cyc("hdr_gap", 1'b0, 1'b0, NONE);
    end
    cyc("abort_edge", 1'b1, 1'b1, NONE);
    cyc("abort_idle", 1'b0, 1'b1, NONE);
    header({7'h2A, 1'b0}, 1'b1);
    data(8, 1'b0);
    end_txn();
    // async reset mid READ_SHIFT
    header({7'h15, 1'b1}, 1'b0);
    data(3, 1'b1);
    #3;
    sb.push_back(NONE);
    rst_n = 1'b0;
    #1 chk("async_reset");
    cyc("in_reset", 1'b1, 1'b1, NONE);
    cyc("in_reset", 1'b1, 1'b1, NONE);
    #4 rst_n = 1'b1;
    cyc("post_reset", 1'b1, 1'b1, NONE);
    cyc("post_reset", 1'b1, 1'b1, NONE);
    header({7'h2A, 1'b0}, 1'b0);
    data(8, 1'b0);
    end_txn();
    // back-to-back write 0x7F <- 0x01, then read 0x7F
    header({7'h7F, 1'b0}, 1'b0);
    data(8, 1'b0);
    end_txn();
    header({7'h7F, 1'b1}, 1'b0);
    data(8, 1'b1);
    end_txn();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
